// File: rtl/wb_nchan_decoder.sv
`default_nettype none
// wb_nchan_decoder: Wishbone aperture split into NUM_CH windows, with a watchdog that terminates silent or unmapped accesses.
// Optional macro WB_TIMEOUT_LOG_EN adds timeout count/address logging. Rev 1.0
module wb_nchan_decoder #(
  parameter int                   NUM_CH               = 4,
  parameter int                   APERWIDTH            = 17,
  parameter int                   CH_ADR_BITS          = 12,
  parameter int                   DATAWIDTH            = 32,
  parameter logic [DATAWIDTH-1:0] DEFAULT_READ_VALUE   = 32'hBAD_FAB_AC,
  parameter int                   DEFAULT_CNTR_WIDTH   = 3,
  parameter int                   DEFAULT_CNTR_TIMEOUT = 7
) (
  input  logic                        WB_CLK,
  input  logic                        WB_RST_n,
  input  logic [APERWIDTH-1:0]        WBs_ADR,
  input  logic                        WBs_CYC,
  input  logic                        WBs_STB,
  input  logic                        WBs_WE,
  output logic [DATAWIDTH-1:0]        WBs_RD_DAT,
  output logic                        WBs_ACK,
  output logic [NUM_CH-1:0]           WBs_CYC_ch_o,
  input  logic [NUM_CH*DATAWIDTH-1:0] WBs_RD_DAT_ch_i,
  input  logic [NUM_CH-1:0]           WBs_ACK_ch_i,
  output logic                        Timeout_o
`ifdef WB_TIMEOUT_LOG_EN
  ,
  output logic [7:0]                  Timeout_Cnt_o,
  output logic [APERWIDTH-1:0]        Timeout_Adr_o
`endif
);

  localparam int IDXW = APERWIDTH - CH_ADR_BITS;
  localparam logic [DEFAULT_CNTR_WIDTH-1:0] TERM_CNT = DEFAULT_CNTR_WIDTH'(DEFAULT_CNTR_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                        state, state_nxt;
  logic [IDXW-1:0]               idx, idx_nxt, adr_idx;
  logic [DEFAULT_CNTR_WIDTH-1:0] cnt, cnt_nxt;
  logic [NUM_CH-1:0]             cyc_ch_nxt, req_sel;
  logic [DATAWIDTH-1:0]          rd_dat_nxt, sel_dat;
  logic                          ack_nxt, timeout_nxt, sel_ack;
  logic                          unused_sig;

  assign adr_idx    = WBs_ADR[APERWIDTH-1:CH_ADR_BITS];
  assign unused_sig = ^{WBs_WE, WBs_ADR[CH_ADR_BITS-1:0]};

  // Out-of-range indices match no channel, so unmapped windows select nothing and never ack.
  always_comb begin
    req_sel = '0;
    sel_ack = 1'b0;
    sel_dat = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(adr_idx) == i) req_sel[i] = 1'b1;
      if (int'(idx) == i) begin
        sel_ack = WBs_ACK_ch_i[i];
        sel_dat = WBs_RD_DAT_ch_i[i*DATAWIDTH +: DATAWIDTH];
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    cnt_nxt     = cnt;
    cyc_ch_nxt  = WBs_CYC_ch_o;
    rd_dat_nxt  = WBs_RD_DAT;
    ack_nxt     = 1'b0;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (WBs_CYC && WBs_STB) begin
          state_nxt  = ACTIVE;
          idx_nxt    = adr_idx;
          cnt_nxt    = '0;
          cyc_ch_nxt = req_sel;
        end
      end
      ACTIVE: begin
        cnt_nxt = cnt + 1'b1;
        if (!WBs_CYC) begin
          state_nxt  = IDLE;
          cyc_ch_nxt = '0;
        end else if (sel_ack) begin
          state_nxt  = DONE;
          cyc_ch_nxt = '0;
          rd_dat_nxt = sel_dat;
          ack_nxt    = 1'b1;
        end else if (cnt == TERM_CNT) begin
          state_nxt   = DONE;
          cyc_ch_nxt  = '0;
          rd_dat_nxt  = DEFAULT_READ_VALUE;
          ack_nxt     = 1'b1;
          timeout_nxt = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
    if (!WB_RST_n) begin
      state        <= IDLE;
      idx          <= '0;
      cnt          <= '0;
      WBs_CYC_ch_o <= '0;
      WBs_RD_DAT   <= '0;
      WBs_ACK      <= 1'b0;
      Timeout_o    <= 1'b0;
    end else begin
      state        <= state_nxt;
      idx          <= idx_nxt;
      cnt          <= cnt_nxt;
      WBs_CYC_ch_o <= cyc_ch_nxt;
      WBs_RD_DAT   <= rd_dat_nxt;
      WBs_ACK      <= ack_nxt;
      Timeout_o    <= timeout_nxt;
    end
  end

`ifdef WB_TIMEOUT_LOG_EN
  always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
    if (!WB_RST_n) begin
      Timeout_Cnt_o <= '0;
      Timeout_Adr_o <= '0;
    end else if (state == DONE && Timeout_o) begin
      if (Timeout_Cnt_o != 8'hFF) Timeout_Cnt_o <= Timeout_Cnt_o + 8'd1;
      Timeout_Adr_o <= WBs_ADR;
    end
  end
`else
  // Logging disabled: no extra state.
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_nchan_decoder.sv
`default_nettype none
// tb_wb_nchan_decoder: randomized transactions checked against a transaction-level outcome model.
module tb_wb_nchan_decoder;
  localparam int          NUM_CH = 4;
  localparam int          TO     = 7;
  localparam logic [31:0] DEF    = 32'hBAD_FAB_AC;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [16:0]          wbs_adr = '0;
  logic                 cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [31:0]          rd_dat;
  logic                 ack;
  logic [NUM_CH-1:0]    cyc_ch;
  logic [NUM_CH*32-1:0] rd_dat_ch = '0;
  logic [NUM_CH-1:0]    ack_ch = '0;
  logic                 timeout;
`ifdef WB_TIMEOUT_LOG_EN
  logic [7:0]           to_cnt_o;
  logic [16:0]          to_adr_o;
  int                   m_to_cnt = 0;
  logic [16:0]          m_to_adr = '0;
`endif

  always #5 clk = ~clk;

  wb_nchan_decoder dut (
    .WB_CLK          (clk),
    .WB_RST_n        (rst_n),
    .WBs_ADR         (wbs_adr),
    .WBs_CYC         (cyc),
    .WBs_STB         (stb),
    .WBs_WE          (we),
    .WBs_RD_DAT      (rd_dat),
    .WBs_ACK         (ack),
    .WBs_CYC_ch_o    (cyc_ch),
    .WBs_RD_DAT_ch_i (rd_dat_ch),
    .WBs_ACK_ch_i    (ack_ch),
    .Timeout_o       (timeout)
`ifdef WB_TIMEOUT_LOG_EN
    ,
    .Timeout_Cnt_o   (to_cnt_o),
    .Timeout_Adr_o   (to_adr_o)
`endif
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] last_dat = '0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // sel < 0: every channel gets random ack noise; otherwise channel sel acks only when ack_sel.
  task automatic drive_slaves(input int sel, input bit ack_sel, input logic [31:0] dat);
    for (int i = 0; i < NUM_CH; i++) begin
      ack_ch[i] = (i == sel) ? ack_sel : 1'($urandom_range(0, 1));
      rd_dat_ch[i*32 +: 32] = (i == sel && ack_sel) ? dat : $urandom;
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_ack"}, {31'b0, ack}, 32'd0);
    check_eq({tag, "_sel"}, {28'b0, cyc_ch}, 32'd0);
    check_eq({tag, "_to"}, {31'b0, timeout}, 32'd0);
    check_eq({tag, "_hold"}, rd_dat, last_dat);
`ifdef WB_TIMEOUT_LOG_EN
    check_eq({tag, "_tocnt"}, {24'b0, to_cnt_o}, 32'(m_to_cnt));
    check_eq({tag, "_toadr"}, {15'b0, to_adr_o}, {15'b0, m_to_adr});
`endif
  endtask

  // kind: 0 = slave ack, 1 = timeout, 2 = master abort
  task automatic run_txn(input logic [16:0] adr, input int k, input int abort_a,
                         input bit hold, input logic [31:0] dat);
    int          idx, kind, end_t;
    bit          mapped;
    logic [3:0]  sel;
    logic [31:0] exp_dat;
    idx    = int'(adr[16:12]);
    mapped = (idx < NUM_CH);
    sel    = mapped ? 4'(1 << idx) : 4'b0;
    if (mapped && k <= TO) begin kind = 0; end_t = k; end
    else                   begin kind = 1; end_t = TO; end
    if (abort_a >= 0 && abort_a < end_t) begin kind = 2; end_t = abort_a; end

    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'($urandom_range(0, 1)); wbs_adr = adr;
    drive_slaves(-1, 1'b0, '0);
    @(negedge clk);
    check_idle("req");

    for (int t = 0; t <= end_t; t++) begin
      @(posedge clk); #1;
      cyc = !(kind == 2 && t == end_t); stb = cyc;
      drive_slaves(mapped ? idx : -1, (kind == 0 && t == end_t), dat);
      @(negedge clk);
      check_eq("act_sel", {28'b0, cyc_ch}, {28'b0, sel});
      check_eq("act_ack", {31'b0, ack}, 32'd0);
    end

    @(posedge clk); #1;
    cyc = (kind != 2) && hold; stb = cyc;
    drive_slaves(-1, 1'b0, '0);
    @(negedge clk);
    check_eq("end_sel", {28'b0, cyc_ch}, 32'd0);
    if (kind == 2) begin
      check_eq("abort_ack", {31'b0, ack}, 32'd0);
      check_eq("abort_to", {31'b0, timeout}, 32'd0);
      check_eq("abort_hold", rd_dat, last_dat);
    end else begin
      exp_dat = (kind == 0) ? dat : DEF;
      check_eq("done_ack", {31'b0, ack}, 32'd1);
      check_eq("done_dat", rd_dat, exp_dat);
      check_eq("done_to", {31'b0, timeout}, {31'b0, (kind == 1)});
      last_dat = exp_dat;
`ifdef WB_TIMEOUT_LOG_EN
      if (kind == 1) begin
        if (m_to_cnt < 255) m_to_cnt++;
        m_to_adr = adr;
      end
`endif
    end
  endtask

  task automatic reset_mid_active();
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; wbs_adr = 17'h02000;
    drive_slaves(-1, 1'b0, '0);
    repeat (2) begin
      @(posedge clk); #1;
      drive_slaves(2, 1'b0, '0);
    end
    @(negedge clk);
    check_eq("rst_pre_sel", {28'b0, cyc_ch}, 32'h4);
    #2 rst_n = 1'b0;
    #1;
    last_dat = '0;
`ifdef WB_TIMEOUT_LOG_EN
    m_to_cnt = 0;
    m_to_adr = '0;
`endif
    check_idle("rst_async");
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; rst_n = 1'b1;
  endtask

  initial begin
    logic [4:0] ridx;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    run_txn(17'h02004, 3, -1, 1'b0, 32'hCAFE0002);
    run_txn(17'h05000, 0, -1, 1'b0, 32'h11111111);
    run_txn(17'h01000, TO, -1, 1'b0, 32'h0C0FFEE1);
    run_txn(17'h03010, 9, 2, 1'b0, 32'h22222222);
    run_txn(17'h00000, 1, -1, 1'b1, 32'hAAAA0000);
    run_txn(17'h03000, 0, -1, 1'b1, 32'hBBBB0003);
    reset_mid_active();
    run_txn(17'h01008, 2, -1, 1'b0, 32'h5A5A0001);

    for (int n = 0; n < 60; n++) begin
      ridx = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(4, 31)) : 5'($urandom_range(0, 3));
      run_txn({ridx, 12'($urandom)}, int'($urandom_range(0, 9)),
              ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 7)) : -1,
              1'($urandom_range(0, 1)), $urandom);
    end

    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    check_idle("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/wb_nchan_decoder.md
Name: wb_nchan_decoder

Overview:
- Parametrised Wishbone client-side fabric decoder for the FPGA memory aperture; the next generation of the fixed per-peripheral base-address decode.
- Splits the aperture into NUM_CH equal windows, forwards a cycle to the selected channel slave and registers its read data and ACK back to the AHB-to-FPGA bridge.
- Guarantees termination: a watchdog counter acks unmapped or non-responding accesses with DEFAULT_READ_VALUE, so the bridge never hangs.

Parameters:
- NUM_CH, 4: number of channel slaves (1..16).
- APERWIDTH, 17: Wishbone byte-address width.
- CH_ADR_BITS, 12: log2 of the window size in bytes. Channel index = WBs_ADR[APERWIDTH-1:CH_ADR_BITS].
- DATAWIDTH, 32: data bus width.
- DEFAULT_READ_VALUE, 32'hBAD_FAB_AC: read data returned on timeout.
- DEFAULT_CNTR_WIDTH, 3: watchdog counter width.
- DEFAULT_CNTR_TIMEOUT, 7: watchdog terminal count; must be < 2**DEFAULT_CNTR_WIDTH.

Ports:
- WB_CLK  input  1  fabric clock, single clock domain.
- WB_RST_n  input  1  asynchronous, active-low reset.
- WBs_ADR  input  APERWIDTH  master address.
- WBs_CYC  input  1  master cycle.
- WBs_STB  input  1  master strobe.
- WBs_WE  input  1  master write enable. Passed to slaves unmodified outside this block.
- WBs_RD_DAT  output  DATAWIDTH  registered read data to master.
- WBs_ACK  output  1  registered acknowledge to master.
- WBs_CYC_ch_o  output  NUM_CH  registered one-hot per-channel cycle select.
- WBs_RD_DAT_ch_i  input  NUM_CH*DATAWIDTH  concatenated slave read data; channel i occupies [i*DATAWIDTH +: DATAWIDTH].
- WBs_ACK_ch_i  input  NUM_CH  per-channel slave acknowledge.
- Timeout_o  output  1  one-cycle pulse, coincident with WBs_ACK, when an access terminated by timeout.

Behaviour:
- Reset (WB_RST_n low, asynchronous): state IDLE. WBs_ACK=0, WBs_RD_DAT=0, WBs_CYC_ch_o=0, Timeout_o=0, counter=0, latched index=0.
- IDLE:
  - On WBs_CYC & WBs_STB: latch channel index and go to ACTIVE; counter cleared.
  - If the index is < NUM_CH, set WBs_CYC_ch_o[idx]=1; otherwise all zeros (unmapped).
- ACTIVE:
  - Counter increments each cycle.
  - If mapped and WBs_ACK_ch_i[idx]=1: capture that channel's read data into WBs_RD_DAT and go to DONE; WBs_CYC_ch_o cleared.
  - Else if counter == DEFAULT_CNTR_TIMEOUT: WBs_RD_DAT=DEFAULT_READ_VALUE, flag timeout, go to DONE, WBs_CYC_ch_o cleared.
  - Slave ACK on the same cycle as terminal count: slave ACK wins, no timeout.
  - WBs_CYC deasserted by master: abort to IDLE, clear WBs_CYC_ch_o, no ACK, no timeout.
- DONE:
  - WBs_ACK=1 for exactly one cycle; Timeout_o=1 if flagged.
  - Next state is IDLE. A new request is accepted no earlier than the cycle after DONE, even if STB is still high.
- Latency:
  - Master STB at cycle 0; ACTIVE from cycle 1; slave ACK at cycle 1+k gives WBs_ACK at cycle 2+k. Minimum is 2.
  - Timeout: WBs_ACK DEFAULT_CNTR_TIMEOUT+1 cycles after ACTIVE entry.
- ACKs on non-selected channels are ignored.
- Acks from a slave while in IDLE or DONE are ignored.
- WBs_RD_DAT holds its last value outside DONE.
- Writes follow the same path; read data is don't-care to the master.

Optional Feature:
- Macro: WB_TIMEOUT_LOG_EN.
- When defined, two extra outputs are added:
  - Timeout_Cnt_o[7:0]: saturating count of timed-out accesses; holds at 8'hFF.
  - Timeout_Adr_o[APERWIDTH-1:0]: WBs_ADR captured at the latest timeout.
  - Both reset to 0 and update on the DONE cycle.
- When undefined, neither port nor its logic exists. Core behaviour is identical either way.

Test Plan:
- Read 0x02004, channel 2 acks 3 cycles after select with 32'hCAFE0002 -> WBs_CYC_ch_o=4'b0100 during ACTIVE, WBs_ACK one cycle with WBs_RD_DAT=32'hCAFE0002, Timeout_o=0.
- Read 0x05000 (index 5, unmapped, NUM_CH=4) -> WBs_CYC_ch_o=0, WBs_ACK 8 cycles after ACTIVE entry with 32'hBAD_FAB_AC, Timeout_o=1; with WB_TIMEOUT_LOG_EN, Timeout_Cnt_o=1 and Timeout_Adr_o=17'h05000.
- Channel 1 ack coincident with terminal count -> slave data returned, Timeout_o=0.
- Master drops WBs_CYC two cycles into ACTIVE -> IDLE, no WBs_ACK, WBs_CYC_ch_o=0 next cycle.
- WB_RST_n pulsed low mid-ACTIVE -> outputs zero immediately without a clock edge; next request decodes normally.
- Back-to-back requests to channels 0 then 3 with STB held -> second select is asserted only after the first WBs_ACK cycle, and each master ACK lasts exactly one cycle.
